// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for avalon_uart_ctrl
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_BAUD    = 2'd2;
    localparam logic [1:0] ADDR_LINE    = 2'd3;

    localparam int CTRL_RIE  = 0;
    localparam int CTRL_WIE  = 1;
    localparam int CTRL_OVR  = 2;
    localparam int CTRL_RINT = 8;
    localparam int CTRL_WINT = 9;

    localparam int DATA_PERR  = 9;
    localparam int DATA_FERR  = 10;
    localparam int DATA_VALID = 15;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with registered count/full/empty
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + (AW+1)'(1);
                    empty <= 1'b0;
                    full  <= (count == (AW+1)'(DEPTH-1));
                end
                2'b01: begin
                    count <= count - (AW+1)'(1);
                    full  <= 1'b0;
                    empty <= (count == (AW+1)'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/avalon_uart_ctrl.sv
// rtl/avalon_uart_ctrl.sv - Avalon-MM UART with programmable baud, parity and FIFOs
module avalon_uart_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 128,
    parameter int DIV_WIDTH       = 16,
    parameter int DEFAULT_DIVISOR = 433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        UART_RXD,
    output logic        irq,
    output logic [31:0] readdata,
    output logic        UART_TXD
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = DATA_WIDTH + 2;

    logic                  wr_acc, rd_acc;
    logic [DIV_WIDTH-1:0]  divisor;
    logic [2:0]            line_cfg;
    logic                  read_irq_en, write_irq_en, rx_overrun;
    logic                  tx_wr_pend;
    logic [DATA_WIDTH-1:0] tx_wr_data;
    logic                  tx_pop, tx_full, tx_empty;
    logic [DATA_WIDTH-1:0] tx_fifo_data;
    logic [CW-1:0]         tx_count, rx_count;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [RW-1:0]         rx_push_data, rx_fifo_data;
    logic [15:0]           tx_space;
    logic                  read_int, write_int;
    logic [31:0]           rd_mux;
    logic                  unused_bits;

    assign wr_acc    = chipselect & write & byteenable[0];
    assign rd_acc    = chipselect & read & byteenable[0];
    assign tx_space  = 16'(FIFO_DEPTH) - 16'(tx_count);
    assign read_int  = read_irq_en & ~rx_empty;
    assign write_int = write_irq_en & (tx_space >= 16'(3 * FIFO_DEPTH / 4));
    assign rx_pop    = rd_acc & (address == ADDR_DATA) & ~rx_empty;
    assign unused_bits = &{1'b0, byteenable[3:1], writedata[31:DIV_WIDTH], tx_full};

    always_ff @(posedge clk) begin
        if (reset) begin
            divisor      <= DIV_WIDTH'(DEFAULT_DIVISOR);
            line_cfg     <= '0;
            read_irq_en  <= 1'b0;
            write_irq_en <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_wr_pend   <= 1'b0;
            tx_wr_data   <= '0;
            irq          <= 1'b0;
        end else begin
            tx_wr_pend <= 1'b0;
            irq        <= read_int | write_int;
            if (wr_acc) begin
                case (address)
                    ADDR_DATA: begin
                        tx_wr_pend <= 1'b1;
                        tx_wr_data <= writedata[DATA_WIDTH-1:0];
                    end
                    ADDR_CONTROL: begin
                        read_irq_en  <= writedata[CTRL_RIE];
                        write_irq_en <= writedata[CTRL_WIE];
                        if (writedata[CTRL_OVR]) rx_overrun <= 1'b0;
                    end
                    ADDR_BAUD: divisor <= (writedata[DIV_WIDTH-1:0] < DIV_WIDTH'(3)) ?
                                          DIV_WIDTH'(3) : writedata[DIV_WIDTH-1:0];
                    default: line_cfg <= writedata[2:0];
                endcase
            end
            if (rx_push & rx_full & ~rx_pop) rx_overrun <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: begin
                rd_mux[31:16]      = 16'(rx_count);
                rd_mux[DATA_VALID] = ~rx_empty;
                if (!rx_empty) begin
                    rd_mux[DATA_FERR]         = rx_fifo_data[RW-1];
                    rd_mux[DATA_PERR]         = rx_fifo_data[RW-2];
                    rd_mux[DATA_WIDTH-1:0]    = rx_fifo_data[DATA_WIDTH-1:0];
                end
            end
            ADDR_CONTROL: begin
                rd_mux[31:16]     = tx_space;
                rd_mux[CTRL_WINT] = write_int;
                rd_mux[CTRL_RINT] = read_int;
                rd_mux[CTRL_OVR]  = rx_overrun;
                rd_mux[CTRL_WIE]  = write_irq_en;
                rd_mux[CTRL_RIE]  = read_irq_en;
            end
            ADDR_BAUD: rd_mux[DIV_WIDTH-1:0] = divisor;
            default:   rd_mux[2:0] = line_cfg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       readdata <= '0;
        else if (rd_acc) readdata <= rd_mux;
    end

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_wr_pend), .push_data(tx_wr_data),
        .pop(tx_pop), .pop_data(tx_fifo_data), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    uart_sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_push_data),
        .pop(rx_pop), .pop_data(rx_fifo_data), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

    tx_state_e             tx_state, tx_next;
    logic                  tx_load, tx_bit_end, tx_line, txd_q;
    logic [DIV_WIDTH-1:0]  tx_cnt, tx_div;
    logic [2:0]            tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par_bit, tx_par_en, tx_two_stop;

    assign tx_bit_end = (tx_cnt == tx_div);
    assign tx_pop     = tx_load;
    assign UART_TXD   = txd_q;

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // Reloading straight from a stop bit lets queued bytes go out with no idle gap
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_line = 1'b1;
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_next = TX_START;
                tx_load = 1'b1;
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end && tx_bit == 3'(DATA_WIDTH-1))
                    tx_next = tx_par_en ? TX_PARITY : TX_STOP1;
            end
            TX_PARITY: begin
                tx_line = tx_par_bit;
                if (tx_bit_end) tx_next = TX_STOP1;
            end
            TX_STOP1, TX_STOP2: if (tx_bit_end) begin
                if (tx_state == TX_STOP1 && tx_two_stop) tx_next = TX_STOP2;
                else if (!tx_empty) begin
                    tx_next = TX_START;
                    tx_load = 1'b1;
                end else tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt      <= '0;
            tx_div      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_par_bit  <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            txd_q <= tx_line;
            if (tx_load) begin
                tx_cnt      <= '0;
                tx_bit      <= '0;
                tx_div      <= divisor;
                tx_shift    <= tx_fifo_data;
                tx_par_en   <= parity_enabled(line_cfg[1:0]);
                tx_par_bit  <= (^tx_fifo_data) ^ (line_cfg[1:0] == PAR_ODD);
                tx_two_stop <= line_cfg[2];
            end else if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else tx_cnt <= tx_cnt + DIV_WIDTH'(1);
        end
    end

    rx_state_e             rx_state, rx_next;
    logic                  rxd_s1, rxd_s2, rxd_prev;
    logic                  rx_load, rx_sample;
    logic [DIV_WIDTH-1:0]  rx_cnt, rx_div;
    logic [2:0]            rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [1:0]            rx_mode;
    logic                  rx_perr;

    // Start is checked at half a bit; every later sample is a full bit after the previous one
    assign rx_sample    = (rx_state == RX_START) ? (rx_cnt == (rx_div >> 1)) : (rx_cnt == rx_div);
    assign rx_push_data = {~rxd_s2, rx_perr, rx_shift};

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        rx_load = 1'b0;
        rx_push = 1'b0;
        case (rx_state)
            RX_IDLE: if (rxd_prev & ~rxd_s2) begin
                rx_next = RX_START;
                rx_load = 1'b1;
            end
            RX_START:  if (rx_sample) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit == 3'(DATA_WIDTH-1))
                           rx_next = parity_enabled(rx_mode) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) begin
                rx_push = 1'b1;
                rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_mode  <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rxd_s1   <= UART_RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            if (rx_load) begin
                rx_cnt  <= '0;
                rx_bit  <= '0;
                rx_div  <= divisor;
                rx_mode <= line_cfg[1:0];
                rx_perr <= 1'b0;
            end else if (rx_sample) begin
                rx_cnt <= '0;
                if (rx_state == RX_DATA) begin
                    rx_shift <= {rxd_s2, rx_shift[DATA_WIDTH-1:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
                if (rx_state == RX_PARITY)
                    rx_perr <= rxd_s2 ^ (^rx_shift) ^ (rx_mode == PAR_ODD);
            end else rx_cnt <= rx_cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_avalon_uart_ctrl.sv
// tb/tb_avalon_uart_ctrl.sv - directed self-checking bench for avalon_uart_ctrl
module tb_avalon_uart_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        rxd;
    logic        irq;
    logic [31:0] readdata;
    logic        txd;

    int checks = 0;
    int errors = 0;

    logic [31:0]  rd;
    logic [119:0] wave;
    logic [10:0]  fb;
    logic         found;

    always #5 clk = ~clk;

    avalon_uart_ctrl dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .UART_RXD(rxd), .irq(irq), .readdata(readdata), .UART_TXD(txd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = 4'hF;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a; byteenable = 4'hF;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic has_par,
                              input logic par, input logic stop);
        rxd = 1'b0;
        repeat (p) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (p) @(posedge clk); #1;
        end
        if (has_par) begin
            rxd = par;
            repeat (p) @(posedge clk); #1;
        end
        rxd = stop;
        repeat (p) @(posedge clk); #1;
        rxd = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; byteenable = '0;
        read = 1'b0; write = 1'b0; writedata = '0; rxd = 1'b1;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;

        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_txd", 32'(txd), 32'h1);
        bus_read(2'd1, rd); check("rst_control", rd, 32'h0080_0000);
        bus_read(2'd2, rd); check("rst_baud", rd, 32'd433);
        bus_read(2'd3, rd); check("rst_line", rd, 32'h0);
        bus_write(2'd2, 32'd1);
        bus_read(2'd2, rd); check("baud_clamp", rd, 32'd3);

        // TX: divisor 9, even parity, 0x55
        bus_write(2'd2, 32'd9);
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h55);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (txd == 1'b0) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("tx_start_seen", 32'(found), 32'h1);
        wave[0] = txd;
        for (int i = 1; i < 120; i++) begin
            @(posedge clk); #1;
            wave[i] = txd;
        end
        fb[0] = 1'b0; fb[8:1] = 8'h55; fb[9] = 1'b0; fb[10] = 1'b1;
        for (int k = 0; k < 11; k++)
            check($sformatf("tx_bit%0d", k), 32'(wave[k*10 +: 10]), 32'({10{fb[k]}}));
        check("tx_idle_after", 32'(wave[119:110]), 32'h3FF);

        // RX: odd parity, bad parity bit and stop=0
        bus_write(2'd3, 32'd2);
        send_frame(8'hA3, 10, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk); #1;
        bus_read(2'd0, rd); check("rx_ferr_perr", rd, 32'h0001_86A3);
        bus_read(2'd0, rd); check("rx_empty_read", rd, 32'h0);

        // RX: good even-parity frame
        bus_write(2'd3, 32'd1);
        send_frame(8'h3C, 10, 1'b1, 1'b0, 1'b1);
        repeat (20) @(posedge clk); #1;
        bus_read(2'd0, rd); check("rx_good_even", rd, 32'h0001_803C);

        // False start glitch
        bus_write(2'd2, 32'd15);
        rxd = 1'b0;
        repeat (3) @(posedge clk); #1;
        rxd = 1'b1;
        repeat (60) @(posedge clk); #1;
        bus_read(2'd0, rd); check("false_start", rd, 32'h0);

        // Overrun: 129 frames, no parity, divisor 3
        bus_write(2'd2, 32'd3);
        bus_write(2'd3, 32'd0);
        for (int i = 1; i <= 129; i++) begin
            send_frame(8'(i), 4, 1'b0, 1'b0, 1'b1);
            repeat (4) @(posedge clk); #1;
        end
        repeat (10) @(posedge clk); #1;
        bus_read(2'd1, rd); check("ovr_control", rd, 32'h0080_0004);
        bus_read(2'd0, rd); check("ovr_first", rd, 32'h0080_8001);
        for (int i = 2; i <= 127; i++) bus_read(2'd0, rd);
        bus_read(2'd0, rd); check("ovr_last_kept", rd, 32'h0001_8080);
        bus_read(2'd0, rd); check("ovr_129_lost", rd, 32'h0);
        bus_write(2'd1, 32'd4);
        bus_read(2'd1, rd); check("ovr_cleared", rd, 32'h0080_0000);

        // Read interrupt
        bus_write(2'd1, 32'd1);
        check("irq_idle", 32'(irq), 32'h0);
        send_frame(8'h5A, 4, 1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (irq) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("irq_rise", 32'(found), 32'h1);
        bus_read(2'd1, rd); check("irq_control", rd, 32'h0080_0101);
        bus_read(2'd0, rd); check("irq_data", rd, 32'h0001_805A);
        @(posedge clk); #1;
        check("irq_fall", 32'(irq), 32'h0);

        // Write interrupt: empty TX FIFO has full space
        bus_write(2'd1, 32'd2);
        @(posedge clk); #1;
        check("wirq_rise", 32'(irq), 32'h1);
        bus_read(2'd1, rd); check("wirq_control", rd, 32'h0080_0202);
        bus_write(2'd1, 32'd0);
        @(posedge clk); #1;
        check("wirq_fall", 32'(irq), 32'h0);

        // Reset mid-frame
        bus_write(2'd2, 32'd9);
        bus_write(2'd3, 32'd0);
        bus_write(2'd0, 32'h00);
        repeat (30) @(posedge clk); #1;
        check("tx_mid_frame_low", 32'(txd), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("tx_reset_abort", 32'(txd), 32'h1);
        reset = 1'b0;
        bus_read(2'd1, rd); check("post_rst_control", rd, 32'h0080_0000);
        bus_read(2'd2, rd); check("post_rst_baud", rd, 32'd433);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_uart_ctrl.md
# avalon_uart_ctrl

Parametrised Avalon-MM UART for the SOPC peripheral set. It has configurable data width and FIFO depth, a run-time programmable baud divisor, and selectable parity (none, even or odd). It adds optional two-stop-bit transmit, framing-error capture, and a sticky RX-overrun flag. It is a drop-in slave on the system interconnect: a 2-bit word address, a registered read path, and one level interrupt to the CPU.

## Interface
- DATA_WIDTH, 8, payload bits per frame; legal range 5..8.
- FIFO_DEPTH, 128, entries per FIFO; power of two, 4..256.
- DIV_WIDTH, 16, baud divisor register width.
- DEFAULT_DIVISOR, 433, divisor loaded at reset.

Ports (clock and reset first):
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address: 0 DATA, 1 CONTROL, 2 BAUD, 3 LINE.
- chipselect  in  1  slave select.
- byteenable  in  4  only bit 0 is qualifying; an access with byteenable[0]=0 has no side effect.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- UART_RXD  in  1  asynchronous serial input; idles high.
- irq  out  1  registered level interrupt.
- readdata  out  32  registered read data.
- UART_TXD  out  1  serial output; idles high.

## Operation
- Bit period is divisor+1 clk cycles.
- BAUD write: writedata[DIV_WIDTH-1:0]; values below 3 are stored as 3.
- LINE register:
  - [1:0] parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
  - [2] stop bits: 0 = one, 1 = two (transmit only).
- Both TX and RX latch divisor and LINE at frame start. A write mid-frame takes effect on the next frame.
- DATA write (byteenable[0]=1): pushes writedata[DATA_WIDTH-1:0] into the TX FIFO. When the FIFO is full the write is dropped silently.
- DATA read (byteenable[0]=1) pops the RX FIFO. Each RX entry is {framing_err, parity_err, data}. Read fields:
  - [31:16] rx count, zero-extended.
  - [15] valid: count was nonzero.
  - [10] framing error.
  - [9] parity error.
  - [DATA_WIDTH-1:0] data.
  - All other bits are 0.
  - A read of an empty FIFO returns valid=0 and pops nothing.
- CONTROL read fields:
  - [31:16] tx space.
  - [9] write_interrupt.
  - [8] read_interrupt.
  - [2] rx_overrun.
  - [1] write_irq_en.
  - [0] read_irq_en.
- CONTROL write:
  - [1:0] set the enables.
  - Writing 1 to [2] clears rx_overrun.
- read_interrupt = read_irq_en & (rx count ≠ 0).
- write_interrupt = write_irq_en & (tx space ≥ 3·FIFO_DEPTH/4).
- irq = OR of both interrupts, registered.
- RX path:
  - 2-flop synchroniser, reset value 1.
  - FSM: IDLE → START on a falling edge.
  - START samples at half a bit period. If the line is high it was a false start: return to IDLE, push nothing.
  - DATA samples DATA_WIDTH bits, LSB first, at mid-bit.
  - PARITY is present only if parity is enabled. parity_err = mismatch against the expected even/odd parity; 0 when parity is none.
  - STOP samples one stop bit at mid-bit; framing_err = (sample==0).
  - After STOP, push the entry and return to IDLE immediately, so back-to-back frames resync.
  - A push while the RX FIFO is full discards the frame and sets rx_overrun.
- TX path:
  - FSM: IDLE → START (pop FIFO) → DATA (LSB first) → PARITY (if enabled) → STOP1 → STOP2 (if two stop bits) → IDLE.
  - If the FIFO is non-empty at the end of the last stop bit, the next START begins the following cycle, with no idle gap.
- FIFOs: a simultaneous push and pop on a full or non-empty FIFO both succeed and the count is unchanged. On an empty FIFO a simultaneous pop is ignored and the push is accepted.

## Timing
- Reset values:
  - readdata = 0, irq = 0, UART_TXD = 1.
  - Enables = 0, rx_overrun = 0.
  - Divisor = DEFAULT_DIVISOR, LINE = 0.
  - FIFOs empty; both FSMs in IDLE.
- Reset asserted mid-frame aborts the frame: TXD goes to 1 on the next edge and any partial RX byte is discarded.
- Read latency is 1 cycle: readdata is valid the cycle after the read strobe. Status reflects the state before that access's pop.
- A DATA write is registered, then pushed: it is visible in tx space 2 cycles after the strobe.
- TX start bit begins 1–2 cycles after a push into an empty FIFO with the FSM idle. Every bit lasts exactly divisor+1 cycles.
- irq follows its interrupt condition by 1 cycle. Interrupts are combinational from registered state, so total irq latency from a FIFO change is ≤2 cycles.

## Structure
- Package uart_pkg:
  - Parity-mode enum.
  - TX and RX state enums.
  - Register address constants.
  - CONTROL and DATA bit-position constants.
- Sub-module uart_sync_fifo (WIDTH, DEPTH):
  - Registered count, full and empty flags.
  - Instantiated twice: TX with width DATA_WIDTH, RX with width DATA_WIDTH+2.
- Baud counters and the RX/TX FSMs live in the top module.

## Test plan
- Reset: all reset values hold. CONTROL reads 0x0080_0000 (FIFO_DEPTH=128). A BAUD write of 1 reads back 3.
- TX: divisor=9, LINE=01, write 0x55. TXD shows a start bit, then 1,0,1,0,1,0,1,0, parity 0, stop 1. Each bit is 10 cycles; the frame is 110 cycles.
- RX framing/parity: LINE=10, drive 0xA3 with a bad parity bit and stop=0. A DATA read returns [15]=1, [10]=1, [9]=1, data 0xA3.
- False start: a 3-cycle low glitch at divisor=15 produces no push, and rx count stays 0.
- Overrun: drive 129 frames with no reads. Count is 128, rx_overrun=1, and the 129th byte is lost. Writing CONTROL[2]=1 clears it.
- Interrupts: read_irq_en=1, then one RX frame. irq rises ≤2 cycles after the push and falls ≤2 cycles after the DATA read empties the FIFO.
